matrix_scan_driver: RTL

//  Downstream of the level-to-bargraph codec. Consumes the two 32-bit row words
//  (red = upper half row, red2 = mirrored lower half row) selected by linesel.

---
 rtl/matrix_scan_driver.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/matrix_scan_driver.sv
// HUB75 row scanner: shifts red/red2 MSB-first, latches, lights the row for ON_CYCLES, steps linesel.
// Latency: row words sampled on last SETTLE cycle; row period SETTLE_CYC + 2*DIV*COLS + ON_CYCLES + 2 clks.
// Backpressure: none; linesel_en gates scanning and is only looked at in IDLE and NEXT.
module matrix_scan_driver #(
  parameter int COLS       = 32,
  parameter int ROWS       = 8,
  parameter int DIV        = 1,
  parameter int SETTLE_CYC = 2,
  parameter int ON_CYCLES  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            linesel_en,
  input  logic [COLS-1:0] red,
  input  logic [COLS-1:0] red2,
  output logic [2:0]      linesel,
  output logic            r1,
  output logic            r2,
  output logic            sclk,
  output logic            lat,
  output logic            oe_n,
  output logic            frame_start
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_LATCH   = 3'd3;
  localparam logic [2:0] S_DISPLAY = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;

  localparam int CNT_MAX = (SETTLE_CYC > ON_CYCLES) ? SETTLE_CYC : ON_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(COLS + 1);
  localparam int DIV_W   = $clog2(DIV + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST     = CNT_W'(ON_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(COLS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(DIV - 1);
  localparam logic [2:0]       ROW_LAST    = 3'(ROWS - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [COLS-1:0]  sr1;
  logic [COLS-1:0]  sr2;
  logic [2:0]       linesel_inc;

  // Serial data comes straight off the shift register MSB, so it is a flop output.
  assign r1 = sr1[COLS-1];
  assign r2 = sr2[COLS-1];

  assign linesel_inc = (linesel == ROW_LAST) ? 3'd0 : linesel + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      sr1         <= '0;
      sr2         <= '0;
      linesel     <= 3'd0;
      sclk        <= 1'b0;
      lat         <= 1'b0;
      oe_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      lat         <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        S_IDLE: begin
          oe_n <= 1'b1;
          sclk <= 1'b0;
          if (linesel_en) begin
            state       <= S_SETTLE;
            cnt         <= '0;
            frame_start <= (linesel == 3'd0);
          end
        end

        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            sr1     <= red;
            sr2     <= red2;
            bit_cnt <= '0;
            div_cnt <= '0;
            sclk    <= 1'b0;
            state   <= S_SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Each bit: DIV clks low, DIV clks high; data moves on the falling edge only.
        S_SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              sr1  <= sr1 << 1;
              sr2  <= sr2 << 1;
              if (bit_cnt == BIT_LAST) begin
                lat   <= 1'b1;
                state <= S_LATCH;
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end
          end
        end

        S_LATCH: begin
          oe_n  <= 1'b0;
          cnt   <= '0;
          state <= S_DISPLAY;
        end

        S_DISPLAY: begin
          if (cnt == ON_LAST) begin
            oe_n  <= 1'b1;
            state <= S_NEXT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // Address only moves here, with the panel dark.
        S_NEXT: begin
          linesel <= linesel_inc;
          if (linesel_en) begin
            state       <= S_SETTLE;
            cnt         <= '0;
            frame_start <= (linesel_inc == 3'd0);
          end else begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
